// File: rtl/score_record_keeper.sv
// Captures a finished game's score, tracks one best score per difficulty level and
// converts current/best to packed BCD with one shared sequential double-dabble shifter.
module score_record_keeper #(
  parameter int SCORE_MAX         = 9999,
  parameter int BIN_W             = 14,
  parameter int CARD_MAX_NUM_SIZE = 4,
  parameter logic [CARD_MAX_NUM_SIZE-1:0] CARD_NUM_EASY   = 4'd6,
  parameter logic [CARD_MAX_NUM_SIZE-1:0] CARD_NUM_NORMAL = 4'd8,
  parameter logic [CARD_MAX_NUM_SIZE-1:0] CARD_NUM_HARD   = 4'd12
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         points_calculated,
  input  logic [BIN_W-1:0]             points,
  input  logic [CARD_MAX_NUM_SIZE-1:0] num_of_cards,
  input  logic                         clear_best,
  output logic [15:0]                  score_bcd,
  output logic [15:0]                  best_bcd,
  output logic                         new_record,
  output logic                         bcd_valid,
  output logic                         busy
);
  // Handshake: points_calculated is a one-cycle valid with no ready; it is accepted
  // only while busy is low, and a pulse seen while busy is dropped, never queued.

  localparam int SH_W = 16 + BIN_W;
  localparam logic [BIN_W-1:0] SCORE_MAX_B = BIN_W'(SCORE_MAX);
  localparam logic [3:0]       LAST_ITER   = 4'(BIN_W - 1);
  localparam logic [1:0]       IDX_NONE    = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_CONV_SCORE, S_CONV_BEST, S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [BIN_W-1:0] score_q;
  logic [1:0]       idx_q;
  logic [BIN_W-1:0] best_q [3];
  logic [BIN_W-1:0] cmp_best_q;
  logic             record_q;
  logic [3:0]       cnt_q;
  logic [SH_W-1:0]  sh_q;
  logic [SH_W-1:0]  sh_step;
  logic [15:0]      park_q;
  logic [BIN_W-1:0] sat_points;
  logic [1:0]       lvl;
  logic [BIN_W-1:0] cur_best;
  logic             can_accept;

  function automatic logic [SH_W-1:0] dd_step(input logic [SH_W-1:0] v);
    logic [SH_W-1:0] t;
    t = v;
    for (int n = 0; n < 4; n++) begin
      if (t[BIN_W+4*n +: 4] >= 4'd5) t[BIN_W+4*n +: 4] = t[BIN_W+4*n +: 4] + 4'd3;
    end
    return t << 1;
  endfunction

  assign sh_step    = dd_step(sh_q);
  assign sat_points = (points > SCORE_MAX_B) ? SCORE_MAX_B : points;
  assign can_accept = (state == S_IDLE) || (state == S_DONE);
  assign busy       = (state == S_LATCH) || (state == S_CONV_SCORE) || (state == S_CONV_BEST);

  always_comb begin
    lvl = IDX_NONE;
    if (num_of_cards == CARD_NUM_EASY)        lvl = 2'd0;
    else if (num_of_cards == CARD_NUM_NORMAL) lvl = 2'd1;
    else if (num_of_cards == CARD_NUM_HARD)   lvl = 2'd2;
  end

  // An unmatched level compares against zero and never writes a best register.
  always_comb begin
    cur_best = '0;
    case (idx_q)
      2'd0:    cur_best = best_q[0];
      2'd1:    cur_best = best_q[1];
      2'd2:    cur_best = best_q[2];
      default: cur_best = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (points_calculated) state_nxt = S_LATCH;
      S_LATCH:        state_nxt = S_CONV_SCORE;
      S_CONV_SCORE:   if (cnt_q == LAST_ITER) state_nxt = S_CONV_BEST;
      S_CONV_BEST:    if (cnt_q == LAST_ITER) state_nxt = S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      score_q    <= '0;
      idx_q      <= IDX_NONE;
      for (int i = 0; i < 3; i++) best_q[i] <= '0;
      cmp_best_q <= '0;
      record_q   <= 1'b0;
      cnt_q      <= '0;
      sh_q       <= '0;
      park_q     <= '0;
      score_bcd  <= '0;
      best_bcd   <= '0;
      new_record <= 1'b0;
      bcd_valid  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE, S_DONE: begin
          // Clear lands on this edge, so a same-cycle score is compared against zero.
          if (clear_best) begin
            for (int i = 0; i < 3; i++) best_q[i] <= '0;
            best_bcd   <= '0;
            new_record <= 1'b0;
          end
          if (points_calculated) begin
            score_q   <= sat_points;
            idx_q     <= lvl;
            bcd_valid <= 1'b0;
          end
        end
        S_LATCH: begin
          record_q   <= 1'b0;
          cmp_best_q <= cur_best;
          if ((idx_q != IDX_NONE) && (score_q > cur_best)) begin
            for (int i = 0; i < 3; i++) if (idx_q == 2'(i)) best_q[i] <= score_q;
            cmp_best_q <= score_q;
            record_q   <= 1'b1;
          end
          sh_q  <= {16'b0, score_q};
          cnt_q <= '0;
        end
        S_CONV_SCORE: begin
          sh_q  <= sh_step;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == LAST_ITER) begin
            park_q <= sh_step[SH_W-1 -: 16];
            sh_q   <= {16'b0, cmp_best_q};
            cnt_q  <= '0;
          end
        end
        S_CONV_BEST: begin
          sh_q  <= sh_step;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == LAST_ITER) begin
            score_bcd  <= park_q;
            best_bcd   <= sh_step[SH_W-1 -: 16];
            new_record <= record_q;
            bcd_valid  <= 1'b1;
            cnt_q      <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_score_record_keeper.sv
// Directed bench for score_record_keeper: a cycle-level score/best model checked
// every cycle, plus literal expectations after each scenario.
module tb_score_record_keeper;
  localparam logic [3:0] EASY = 4'd6, NORMAL = 4'd8, HARD = 4'd12, NOLVL = 4'd3;
  localparam int LAT = 29;

  logic        clk, rst;
  logic        points_calculated, clear_best;
  logic [13:0] points;
  logic [3:0]  num_of_cards;
  logic [15:0] score_bcd, best_bcd;
  logic        new_record, bcd_valid, busy;

  int checks = 0;
  int errors = 0;
  bit started = 0;

  score_record_keeper #(
    .SCORE_MAX(9999), .BIN_W(14), .CARD_MAX_NUM_SIZE(4),
    .CARD_NUM_EASY(EASY), .CARD_NUM_NORMAL(NORMAL), .CARD_NUM_HARD(HARD)
  ) dut (
    .clk(clk), .rst(rst), .points_calculated(points_calculated), .points(points),
    .num_of_cards(num_of_cards), .clear_best(clear_best), .score_bcd(score_bcd),
    .best_bcd(best_bcd), .new_record(new_record), .bcd_valid(bcd_valid), .busy(busy)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // behavioural model: results appear LAT edges after an accepted pulse
  int m_best [3];
  int m_remain, m_score, m_bestv, p_score, p_best;
  bit m_rec, m_valid, p_rec;

  always @(posedge clk) begin
    int s, lv;
    if (rst) begin
      m_best = '{0, 0, 0};
      m_remain = 0; m_score = 0; m_bestv = 0; m_rec = 0; m_valid = 0;
    end else if (m_remain == 0) begin
      if (clear_best) begin
        m_best = '{0, 0, 0};
        m_bestv = 0; m_rec = 0;
      end
      if (points_calculated) begin
        s = (int'(points) > 9999) ? 9999 : int'(points);
        lv = (num_of_cards == EASY) ? 0 : (num_of_cards == NORMAL) ? 1 :
             (num_of_cards == HARD) ? 2 : -1;
        p_score = s; p_best = 0; p_rec = 0;
        if (lv >= 0) begin
          if (s > m_best[lv]) begin
            m_best[lv] = s;
            p_rec = 1;
          end
          p_best = m_best[lv];
        end
        m_valid = 0;
        m_remain = LAT;
      end
    end else begin
      m_remain--;
      if (m_remain == 0) begin
        m_score = p_score; m_bestv = p_best; m_rec = p_rec; m_valid = 1;
      end
    end
  end

  // scoreboard compare, every cycle
  always @(negedge clk) begin
    if (started) begin
      chk("busy", 32'(busy), 32'(m_remain != 0));
      chk("bcd_valid", 32'(bcd_valid), 32'(m_valid));
      chk("score_bcd", 32'(score_bcd), 32'(to_bcd(m_score)));
      chk("best_bcd", 32'(best_bcd), 32'(to_bcd(m_bestv)));
      chk("new_record", 32'(new_record), 32'(m_rec));
    end
  end

  // driver: pulse for one cycle, then count busy cycles; optionally inject a second pulse
  task automatic run(input int p, input logic [3:0] cards, input bit clr,
                     input bit inject, output int n);
    @(negedge clk);
    points = 14'(p); num_of_cards = cards; clear_best = clr; points_calculated = 1'b1;
    @(negedge clk);
    points_calculated = 1'b0; clear_best = 1'b0;
    n = 0;
    while (busy && n < 60) begin
      n++;
      if (inject && n == 5) begin
        points = 14'd8888; num_of_cards = EASY; points_calculated = 1'b1;
      end else begin
        points_calculated = 1'b0;
      end
      @(negedge clk);
    end
    points_calculated = 1'b0;
  endtask

  task automatic expect_result(input string tag, input int n, input logic [15:0] s,
                               input logic [15:0] b, input bit r);
    chk({tag, "_latency"}, 32'(n), 32'(LAT));
    chk({tag, "_score"}, 32'(score_bcd), 32'(s));
    chk({tag, "_best"}, 32'(best_bcd), 32'(b));
    chk({tag, "_rec"}, 32'(new_record), 32'(r));
    chk({tag, "_valid"}, 32'(bcd_valid), 32'd1);
  endtask

  initial begin
    int n;
    rst = 1'b1; points_calculated = 1'b0; clear_best = 1'b0; points = '0; num_of_cards = EASY;
    @(posedge clk);
    started = 1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("idle_score", 32'(score_bcd), 32'h0);
    chk("idle_best", 32'(best_bcd), 32'h0);
    chk("idle_rec", 32'(new_record), 32'h0);
    chk("idle_valid", 32'(bcd_valid), 32'h0);
    chk("idle_busy", 32'(busy), 32'h0);

    run(1234, EASY, 0, 0, n);   expect_result("easy1234", n, 16'h1234, 16'h1234, 1);
    run(1000, EASY, 0, 0, n);   expect_result("easy1000", n, 16'h1000, 16'h1234, 0);
    run(1234, EASY, 0, 0, n);   expect_result("easy_eq", n, 16'h1234, 16'h1234, 0);
    run(12000, HARD, 0, 0, n);  expect_result("hard_sat", n, 16'h9999, 16'h9999, 1);
    run(0, EASY, 0, 0, n);      expect_result("easy0", n, 16'h0000, 16'h1234, 0);
    run(50, HARD, 0, 1, n);     expect_result("ignore_e5", n, 16'h0050, 16'h9999, 0);
    run(77, NOLVL, 0, 0, n);    expect_result("nolvl", n, 16'h0077, 16'h0000, 0);
    run(505, NORMAL, 1, 0, n);  expect_result("clr_norm", n, 16'h0505, 16'h0505, 1);
    run(1500, EASY, 0, 0, n);   expect_result("after_clr", n, 16'h1500, 16'h1500, 1);

    @(negedge clk); clear_best = 1'b1;
    @(negedge clk); clear_best = 1'b0;
    chk("done_clr_best", 32'(best_bcd), 32'h0);
    chk("done_clr_rec", 32'(new_record), 32'h0);
    chk("done_clr_valid", 32'(bcd_valid), 32'h1);
    chk("done_clr_score", 32'(score_bcd), 32'h1500);

    // reset in the middle of a conversion discards it and clears the best registers
    @(negedge clk);
    points = 14'd4321; num_of_cards = EASY; points_calculated = 1'b1;
    @(negedge clk); points_calculated = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_valid", 32'(bcd_valid), 32'h0);
    chk("rst_score", 32'(score_bcd), 32'h0);
    run(5, EASY, 0, 0, n);      expect_result("post_rst", n, 16'h0005, 16'h0005, 1);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
